// File: rtl/gpio_display_arbiter_if.sv
// Display arbitration bundle: per-source requests, locks and display data in,
// grant status and registered display image out.
interface gpio_display_arbiter_if;
   logic [3:0]   req;
   logic [3:0]   lock;
   logic [511:0] src_rows;
   logic [255:0] src_hex;
   logic [3:0]   grant;
   logic [1:0]   owner;
   logic         active;
   logic [127:0] rows_out;
   logic [63:0]  hex_out;

   modport master (
      output req, lock, src_rows, src_hex,
      input  grant, owner, active, rows_out, hex_out
   );

   modport slave (
      input  req, lock, src_rows, src_hex,
      output grant, owner, active, rows_out, hex_out
   );
endinterface

// File: rtl/gpio_display_arbiter.sv
// Round-robin owner of the matrix/hex display with minimum dwell and blanking gap.
// Optional macro GPIO_ARB_LOCK_EN: when defined the owner's lock bit blocks dwell preemption.
module gpio_display_arbiter #(
   parameter logic [25:0] DWELL = 26'd50_000_000,
   parameter logic [7:0]  BLANK = 8'd64
) (
   input  logic                   clock_50,
   input  logic                   reset,
   gpio_display_arbiter_if.slave  arb
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_OWN   = 2'd1,
      S_BLANK = 2'd2
   } state_t;

   state_t        state_r, next_state_s;
   logic [3:0]    grant_r, next_grant_s;
   logic [1:0]    owner_r, next_owner_s;
   logic [1:0]    rr_ptr_r, next_rr_ptr_s;
   logic [25:0]   dwell_cnt_r, next_dwell_cnt_s;
   logic [7:0]    blank_cnt_r, next_blank_cnt_s;
   logic          active_r, next_active_s;
   logic [127:0]  rows_r;
   logic [63:0]   hex_r;
   logic [3:0]    lock_eff_s;
   logic [1:0]    winner_s;
   logic          others_s;
   logic          dwell_done_s;

   // The previous owner sits last in the search order, so it only wins when alone.
   function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] ptr);
      logic [1:0] c1, c2, c3;
      c1 = ptr + 2'd1;
      c2 = ptr + 2'd2;
      c3 = ptr + 2'd3;
      if (r[c1])      rr_pick = c1;
      else if (r[c2]) rr_pick = c2;
      else if (r[c3]) rr_pick = c3;
      else            rr_pick = ptr;
   endfunction

`ifdef GPIO_ARB_LOCK_EN
   assign lock_eff_s = arb.lock;
`else
   logic unused_lock_s;
   assign unused_lock_s = ^arb.lock;
   assign lock_eff_s    = 4'b0000;
`endif

   assign winner_s     = rr_pick(arb.req, rr_ptr_r);
   assign others_s     = |(arb.req & ~grant_r);
   assign dwell_done_s = (dwell_cnt_r == (DWELL - 26'd1));

   // Next-state, grant and counter decode.
   always_comb begin
      next_state_s     = state_r;
      next_grant_s     = grant_r;
      next_owner_s     = owner_r;
      next_rr_ptr_s    = rr_ptr_r;
      next_dwell_cnt_s = dwell_cnt_r;
      next_blank_cnt_s = blank_cnt_r;
      next_active_s    = active_r;
      case (state_r)
         S_IDLE: begin
            if (arb.req != 4'b0000) begin
               next_state_s     = S_OWN;
               next_grant_s     = 4'b0001 << winner_s;
               next_owner_s     = winner_s;
               next_rr_ptr_s    = winner_s;
               next_dwell_cnt_s = 26'd0;
               next_active_s    = 1'b1;
            end else begin
               next_grant_s  = 4'b0000;
               next_active_s = 1'b0;
            end
         end
         S_OWN: begin
            if (!arb.req[owner_r] ||
                (dwell_done_s && others_s && !lock_eff_s[owner_r])) begin
               next_state_s     = S_BLANK;
               next_grant_s     = 4'b0000;
               next_active_s    = 1'b0;
               next_blank_cnt_s = 8'd0;
            end else if (!dwell_done_s) begin
               next_dwell_cnt_s = dwell_cnt_r + 26'd1;
            end else begin
               next_dwell_cnt_s = dwell_cnt_r;
            end
         end
         S_BLANK: begin
            if (blank_cnt_r == (BLANK - 8'd1)) begin
               if (arb.req != 4'b0000) begin
                  next_state_s     = S_OWN;
                  next_grant_s     = 4'b0001 << winner_s;
                  next_owner_s     = winner_s;
                  next_rr_ptr_s    = winner_s;
                  next_dwell_cnt_s = 26'd0;
                  next_active_s    = 1'b1;
               end else begin
                  next_state_s = S_IDLE;
               end
               next_blank_cnt_s = 8'd0;
            end else begin
               next_blank_cnt_s = blank_cnt_r + 8'd1;
            end
         end
         default: begin
            next_state_s  = S_IDLE;
            next_grant_s  = 4'b0000;
            next_active_s = 1'b0;
         end
      endcase
   end

   // State and arbitration registers.
   always_ff @(posedge clock_50 or posedge reset) begin
      if (reset) begin
         state_r     <= S_IDLE;
         grant_r     <= 4'b0000;
         owner_r     <= 2'd0;
         rr_ptr_r    <= 2'd3;
         dwell_cnt_r <= 26'd0;
         blank_cnt_r <= 8'd0;
         active_r    <= 1'b0;
      end else begin
         state_r     <= next_state_s;
         grant_r     <= next_grant_s;
         owner_r     <= next_owner_s;
         rr_ptr_r    <= next_rr_ptr_s;
         dwell_cnt_r <= next_dwell_cnt_s;
         blank_cnt_r <= next_blank_cnt_s;
         active_r    <= next_active_s;
      end
   end

   // Display image lags the grant by one cycle and blanks once OWN is left.
   always_ff @(posedge clock_50 or posedge reset) begin
      if (reset) begin
         rows_r <= 128'd0;
         hex_r  <= 64'd0;
      end else if (state_r == S_OWN) begin
         rows_r <= arb.src_rows[{owner_r, 7'd0} +: 128];
         hex_r  <= arb.src_hex[{owner_r, 6'd0} +: 64];
      end else begin
         rows_r <= 128'd0;
         hex_r  <= 64'd0;
      end
   end

   assign arb.grant    = grant_r;
   assign arb.owner    = owner_r;
   assign arb.active   = active_r;
   assign arb.rows_out = rows_r;
   assign arb.hex_out  = hex_r;

endmodule
